march_fail_logger: RTL and testbench
====================================

// Module: march_fail_logger
// PURPOSE
// - Result-side reader for the March BIST: watches each comparator read-check (address, expected, actual)
//   and logs every mismatching read into a small FIFO.
// - A tester or debug controller drains the log through a valid/ready port during or after the run.
// - Sits beside the March counter/comparator; complements the single GoNoGo bit with failing addresses and data.
// PARAMETERS
// - ADDR_W  8  SRAM address width (256 words)
// - DATA_W  4  SRAM data width
// - DEPTH   8  fail-log FIFO entries; power of two, >=2
// - CNT_W   12 width of the saturating total-fail counter
// PORTS
// - Clock         in   1       single clock, rising edge
// - Reset_n       in   1       asynchronous reset, active-low
// - Bist_start    in   1       pulse: clear log and begin capture
// - Bist_done     in   1       pulse: BIST sequence finished
// - Cmp_valid     in   1       a read-compare is presented this cycle
// - Cmp_addr      in   ADDR_W  address of the compared read
// - Cmp_expected  in   DATA_W  data the March element expects
// - Cmp_actual    in   DATA_W  data returned by SRAM
// - Rd_ready      in   1       reader accepts the head entry
// - Rd_valid      out  1       head entry available (FIFO not empty)
// - Rd_addr       out  ADDR_W  head entry address
// - Rd_expected   out  DATA_W  head entry expected data
// - Rd_actual     out  DATA_W  head entry actual data
// - Fail_count    out  CNT_W   total mismatches this run, saturating at all-ones
// - Overflow      out  1       sticky: a mismatch was dropped because the FIFO was full
// - Log_done      out  1       run finished and log fully drained
// BEHAVIOUR
// - Reset (async, Reset_n=0): state IDLE; FIFO empty; all outputs 0.
// - FSM: IDLE -(Bist_start)-> CAPTURE -(Bist_done)-> DRAIN -(FIFO empty)-> DONE -(Bist_start)-> CAPTURE.
// - Bist_start in any state: next cycle enters CAPTURE. Pointers, Fail_count, Overflow and Log_done clear.
//   A mismatch in the same cycle as Bist_start is discarded.
// - Mismatch = Cmp_valid && (Cmp_actual != Cmp_expected). Logged only in CAPTURE, or in the same cycle as
//   the Bist_done that leaves CAPTURE. Cmp_valid is ignored in IDLE, DRAIN and DONE.
// - Logged mismatch: Fail_count += 1 (holds at 2^CNT_W-1). Entry {addr,expected,actual} is pushed if the
//   FIFO is not full; otherwise it is dropped and Overflow sets.
// - Latency: a mismatch at edge N is visible at the head by edge N+1 if the FIFO was empty. Rd_* are registered.
// - Pop on Rd_valid && Rd_ready, allowed in CAPTURE and DRAIN. Rd_* hold stable while Rd_valid && !Rd_ready.
// - Push and pop in the same cycle when full: both happen; no drop, no Overflow.
// - Push and pop in the same cycle when empty: no pop; the push lands.
// - Pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs equal.
// - DRAIN -> DONE on the cycle the FIFO is empty. Log_done=1 in DONE (Bist_done with an empty FIFO reaches
//   DONE in 2 cycles). Overflow and Fail_count hold until the next Bist_start or reset.
// - Bist_done outside CAPTURE: ignored.
// - Reset mid-run: immediate return to IDLE; log contents are lost.
// CONFIGURATION
// - FAIL_LOG_SYNDROME_EN defined: adds output Fail_bits [DATA_W-1:0].
//   Fail_bits = sticky OR of (expected ^ actual) over all logged mismatches, including dropped ones.
//   Cleared by reset or Bist_start. Identifies stuck I/O bit lines.
// - FAIL_LOG_SYNDROME_EN undefined: port and logic absent; all other behaviour identical.
// TESTING
// - Clean run: Bist_start, 2570 compares with actual==expected, Bist_done
//   -> Fail_count=0, Rd_valid never 1, Log_done=1 two cycles after Bist_done.
// - Single fail: Bist_start, then compare addr=8'h3C exp=4'hA act=4'h8, Rd_ready=0
//   -> next cycle Rd_valid=1, Rd_addr=3C, Rd_expected=A, Rd_actual=8, Fail_count=1; with the macro, Fail_bits=4'h2.
// - Overflow: 10 mismatches at addr 0..9, Rd_ready=0, DEPTH=8
//   -> Fail_count=10, Overflow=1; after Bist_done, 8 pops yield addr 0..7 in order; then Log_done=1.
// - Full + simultaneous pop: FIFO full, Rd_ready=1, mismatch at addr 8'hF0
//   -> no Overflow; the FIFO stays full; addr F0 appears as the last entry.
// - Restart/reset: 3 entries logged, Bist_start asserted with a mismatch the same cycle
//   -> Rd_valid=0, Fail_count=0, Overflow=0.
//   Separately, Reset_n low mid-CAPTURE -> all outputs 0 asynchronously; state IDLE.
// - Saturation: CNT_W=3, 9 mismatches -> Fail_count stays 3'b111.

Source files
------------

// File: rtl/march_fail_logger.sv
// March BIST fail logger.
// Watches comparator read-checks and logs every mismatching read
// {address, expected, actual} into a small FIFO. A tester drains the
// log through a valid/ready port during or after the run. It also keeps
// a saturating total-fail counter and a sticky overflow flag.
//
// Optional feature: define FAIL_LOG_SYNDROME_EN to add the Fail_bits
// output. Fail_bits is the sticky OR of (expected ^ actual) over every
// logged mismatch, including mismatches dropped on overflow, and points
// at stuck I/O bit lines.
module march_fail_logger #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 12
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Bist_start,
  input  logic              Bist_done,
  input  logic              Cmp_valid,
  input  logic [ADDR_W-1:0] Cmp_addr,
  input  logic [DATA_W-1:0] Cmp_expected,
  input  logic [DATA_W-1:0] Cmp_actual,
  input  logic              Rd_ready,
  output logic              Rd_valid,
  output logic [ADDR_W-1:0] Rd_addr,
  output logic [DATA_W-1:0] Rd_expected,
  output logic [DATA_W-1:0] Rd_actual,
  output logic [CNT_W-1:0]  Fail_count,
  output logic              Overflow,
  output logic              Log_done
`ifdef FAIL_LOG_SYNDROME_EN
  ,
  output logic [DATA_W-1:0] Fail_bits
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   wr_ptr_nx, rd_ptr_nx;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] entry_p0;
  logic [ENT_W-1:0] head_nx;
  logic             mismatch_p0;
  logic             log_en;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             drop;
  logic             head_ld;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Compare stage: classify the presented read and decide push/pop/drop.
  assign entry_p0    = {Cmp_addr, Cmp_expected, Cmp_actual};
  assign mismatch_p0 = Cmp_valid && (Cmp_actual != Cmp_expected);
  // Bist_done in the same cycle still finds state CAPTURE, so that
  // final compare is logged; a Bist_start cycle discards the compare.
  assign log_en      = mismatch_p0 && (state_q == S_CAPTURE) && !Bist_start;
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop         = !fifo_empty && Rd_ready && !Bist_start &&
                       ((state_q == S_CAPTURE) || (state_q == S_DRAIN));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push        = log_en && (!fifo_full || pop);
  assign drop        = log_en && fifo_full && !pop;
  assign rd_ptr_nx   = rd_ptr_q + {{PTR_W{1'b0}}, pop};
  assign wr_ptr_nx   = wr_ptr_q + {{PTR_W{1'b0}}, push};
  assign Rd_valid    = !fifo_empty;

  // The next head is the entry being written this cycle when that entry
  // becomes the only one; otherwise it already sits in storage.
  assign head_nx = (push && (rd_ptr_nx == wr_ptr_q)) ? entry_p0
                                                    : mem_q[rd_ptr_nx[PTR_W-1:0]];
  assign head_ld = !Bist_start && (rd_ptr_nx != wr_ptr_nx);

  // Log storage: data only, written at the write pointer on push.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= entry_p0;
  end

  // Control: run FSM, FIFO pointers, fail counter and sticky flags.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      Fail_count <= '0;
      Overflow   <= 1'b0;
      Log_done   <= 1'b0;
    end else if (Bist_start) begin
      state_q    <= S_CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      Fail_count <= '0;
      Overflow   <= 1'b0;
      Log_done   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_nx;
      rd_ptr_q <= rd_ptr_nx;
      if (log_en) Fail_count <= sat_inc(Fail_count);
      if (drop) Overflow <= 1'b1;
      case (state_q)
        S_CAPTURE: if (Bist_done) state_q <= S_DRAIN;
        S_DRAIN: begin
          if (fifo_empty) begin
            state_q  <= S_DONE;
            Log_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered head entry; holds while the reader stalls or the log is empty.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Rd_addr     <= '0;
      Rd_expected <= '0;
      Rd_actual   <= '0;
    end else if (head_ld) begin
      {Rd_addr, Rd_expected, Rd_actual} <= head_nx;
    end
  end

`ifdef FAIL_LOG_SYNDROME_EN
  // Sticky syndrome of flipped bit lines over all logged mismatches.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Fail_bits <= '0;
    end else if (Bist_start) begin
      Fail_bits <= '0;
    end else if (log_en) begin
      Fail_bits <= Fail_bits | (Cmp_expected ^ Cmp_actual);
    end
  end
`endif

endmodule

// File: tb/tb_march_fail_logger.sv
// Bench for march_fail_logger: directed scenarios plus randomized runs,
// all checked every cycle against a queue-based reference model.
module tb_march_fail_logger;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_CAP   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic              Clock;
  logic              Reset_n;
  logic              Bist_start;
  logic              Bist_done;
  logic              Cmp_valid;
  logic [ADDR_W-1:0] Cmp_addr;
  logic [DATA_W-1:0] Cmp_expected;
  logic [DATA_W-1:0] Cmp_actual;
  logic              Rd_ready;
  logic              Rd_valid;
  logic [ADDR_W-1:0] Rd_addr;
  logic [DATA_W-1:0] Rd_expected;
  logic [DATA_W-1:0] Rd_actual;
  logic [CNT_W-1:0]  Fail_count;
  logic              Overflow;
  logic              Log_done;
`ifdef FAIL_LOG_SYNDROME_EN
  logic [DATA_W-1:0] Fail_bits;
`endif

  march_fail_logger #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Bist_start(Bist_start), .Bist_done(Bist_done),
    .Cmp_valid(Cmp_valid), .Cmp_addr(Cmp_addr),
    .Cmp_expected(Cmp_expected), .Cmp_actual(Cmp_actual),
    .Rd_ready(Rd_ready), .Rd_valid(Rd_valid), .Rd_addr(Rd_addr),
    .Rd_expected(Rd_expected), .Rd_actual(Rd_actual),
    .Fail_count(Fail_count), .Overflow(Overflow), .Log_done(Log_done)
`ifdef FAIL_LOG_SYNDROME_EN
    , .Fail_bits(Fail_bits)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // Reference model state: the log as a plain queue plus run phase.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] x;
  } ent_t;

  ent_t              mq[$];
  int                m_cnt;
  bit                m_ovf;
  int                m_phase;
  logic [DATA_W-1:0] m_fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear(input int phase);
    mq.delete();
    m_cnt   = 0;
    m_ovf   = 0;
    m_fb    = '0;
    m_phase = phase;
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge(input logic s, input logic d, input logic v,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e,
                            input logic [DATA_W-1:0] x, input logic r);
    bit   was_empty;
    bit   was_full;
    bit   logm;
    bit   popm;
    ent_t t;
    if (s) begin
      model_clear(P_CAP);
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      logm      = v && (x != e) && (m_phase == P_CAP);
      popm      = !was_empty && r && (m_phase == P_CAP || m_phase == P_DRAIN);
      if (popm) void'(mq.pop_front());
      if (logm) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        m_fb = m_fb | (e ^ x);
        if (!was_full || popm) begin
          t.a = a; t.e = e; t.x = x;
          mq.push_back(t);
        end else begin
          m_ovf = 1;
        end
      end
      if (m_phase == P_CAP && d) m_phase = P_DRAIN;
      else if (m_phase == P_DRAIN && was_empty) m_phase = P_DONE;
    end
  endtask

  task automatic cmp_all();
    chk("rd_valid", Rd_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("rd_addr", Rd_addr, mq[0].a);
      chk("rd_expected", Rd_expected, mq[0].e);
      chk("rd_actual", Rd_actual, mq[0].x);
    end
    chk("fail_count", Fail_count, m_cnt);
    chk("overflow", Overflow, m_ovf);
    chk("log_done", Log_done, m_phase == P_DONE);
`ifdef FAIL_LOG_SYNDROME_EN
    chk("fail_bits", Fail_bits, m_fb);
`endif
  endtask

  task automatic step(input logic s, input logic d, input logic v,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e,
                      input logic [DATA_W-1:0] x, input logic r);
    Bist_start   = s;
    Bist_done    = d;
    Cmp_valid    = v;
    Cmp_addr     = a;
    Cmp_expected = e;
    Cmp_actual   = x;
    Rd_ready     = r;
    @(posedge Clock);
    model_edge(s, d, v, a, e, x, r);
    #1;
    cmp_all();
  endtask

  task automatic start();
    step(1, 0, 0, 8'h00, 4'h0, 4'h0, 0);
  endtask

  task automatic done();
    step(0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
  endtask

  task automatic idle(input logic r);
    step(0, 0, 0, 8'h00, 4'h0, 4'h0, r);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_valid"}, Rd_valid, 0);
    chk({tag, "_rd_addr"}, Rd_addr, 0);
    chk({tag, "_rd_expected"}, Rd_expected, 0);
    chk({tag, "_rd_actual"}, Rd_actual, 0);
    chk({tag, "_fail_count"}, Fail_count, 0);
    chk({tag, "_overflow"}, Overflow, 0);
    chk({tag, "_log_done"}, Log_done, 0);
`ifdef FAIL_LOG_SYNDROME_EN
    chk({tag, "_fail_bits"}, Fail_bits, 0);
`endif
  endtask

  task automatic rand_run(input int n, input int rdy_pct, input int done_div);
    logic              s, d, v, r;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] e, x;
    start();
    for (int i = 0; i < n; i++) begin
      s = ($urandom_range(0, 299) == 0);
      d = ($urandom_range(0, done_div - 1) == 0);
      v = 1'($urandom_range(0, 1));
      a = ADDR_W'($urandom);
      e = DATA_W'($urandom);
      x = ($urandom_range(0, 2) == 0) ? DATA_W'($urandom) : e;
      r = ($urandom_range(0, 99) < rdy_pct);
      step(s, d, v, a, e, x, r);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] e;
    bit                seen_valid;

    Reset_n = 1'b0;
    Bist_start = 0; Bist_done = 0; Cmp_valid = 0;
    Cmp_addr = '0; Cmp_expected = '0; Cmp_actual = '0; Rd_ready = 0;
    model_clear(P_IDLE);
    #3;
    check_zero("reset");
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;

    // Idle: compares and Bist_done before any start are ignored.
    step(0, 1, 1, 8'h11, 4'h1, 4'h2, 1);
    idle(0);

    // Clean run: no mismatches.
    start();
    seen_valid = 0;
    for (int i = 0; i < 2570; i++) begin
      e = DATA_W'($urandom);
      step(0, 0, 1, ADDR_W'(i), e, e, 1'($urandom_range(0, 1)));
      if (Rd_valid) seen_valid = 1;
    end
    done();
    chk("clean_log_done_1cyc", Log_done, 0);
    idle(0);
    chk("clean_log_done_2cyc", Log_done, 1);
    chk("clean_fail_count", Fail_count, 0);
    chk("clean_never_valid", seen_valid, 0);

    // Single fail.
    start();
    step(0, 0, 1, 8'h3C, 4'hA, 4'h8, 0);
    chk("single_rd_valid", Rd_valid, 1);
    chk("single_rd_addr", Rd_addr, 8'h3C);
    chk("single_rd_expected", Rd_expected, 4'hA);
    chk("single_rd_actual", Rd_actual, 4'h8);
    chk("single_fail_count", Fail_count, 1);
`ifdef FAIL_LOG_SYNDROME_EN
    chk("single_fail_bits", Fail_bits, 4'h2);
`endif

    // Overflow: 10 mismatches into an 8-deep log.
    start();
    for (int i = 0; i < 10; i++) step(0, 0, 1, ADDR_W'(i), 4'h5, 4'h4, 0);
    chk("ovf_fail_count", Fail_count, 10);
    chk("ovf_overflow", Overflow, 1);
    done();
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", Rd_addr, i);
      idle(1);
    end
    chk("ovf_drained", Rd_valid, 0);
    idle(0);
    chk("ovf_log_done", Log_done, 1);
    chk("ovf_overflow_holds", Overflow, 1);

    // Full log with a simultaneous pop and push.
    start();
    for (int i = 0; i < 8; i++) step(0, 0, 1, ADDR_W'(i), 4'h0, 4'hF, 0);
    step(0, 0, 1, 8'hF0, 4'h3, 4'h1, 1);
    chk("fullpop_overflow", Overflow, 0);
    chk("fullpop_head", Rd_addr, 8'h01);
    done();
    last_addr = '0;
    for (int i = 0; i < 8; i++) begin
      last_addr = Rd_addr;
      idle(1);
    end
    chk("fullpop_last", last_addr, 8'hF0);

    // Restart with a mismatch in the Bist_start cycle.
    start();
    for (int i = 0; i < 3; i++) step(0, 0, 1, ADDR_W'(8'h20 + i), 4'h7, 4'h6, 0);
    step(1, 0, 1, 8'h55, 4'h1, 4'h0, 0);
    chk("restart_rd_valid", Rd_valid, 0);
    chk("restart_fail_count", Fail_count, 0);
    chk("restart_overflow", Overflow, 0);

    // Randomized runs with different reader pressure.
    rand_run(1500, 80, 40);
    rand_run(1500, 20, 120);
    rand_run(1500, 50, 60);

    // Saturation of the fail counter.
    start();
    for (int i = 0; i < CNT_MAX + 6; i++)
      step(0, 0, 1, ADDR_W'(i), 4'h9, 4'h1, 1'($urandom_range(0, 1)));
    chk("sat_fail_count", Fail_count, CNT_MAX);

    // Asynchronous reset in the middle of a capture.
    start();
    for (int i = 0; i < 3; i++) step(0, 0, 1, ADDR_W'(8'h40 + i), 4'hC, 4'h3, 0);
    #2;
    Reset_n = 1'b0;
    Bist_start = 0; Bist_done = 0; Cmp_valid = 0; Rd_ready = 0;
    #1;
    check_zero("async_rst");
    model_clear(P_IDLE);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    step(0, 1, 1, 8'h77, 4'h2, 4'h3, 1);
    idle(0);
    chk("post_rst_idle_done", Log_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
